// File: rtl/traffic_disp_scan_pkg.sv
// Shared constants and types for the traffic display scanner:
// lamp codes, segment patterns, the digit-slot index and the one-hot lamp check.
package traffic_disp_pkg;

    localparam logic [3:0] LAMP_LEFT   = 4'b0001;
    localparam logic [3:0] LAMP_GREEN  = 4'b0010;
    localparam logic [3:0] LAMP_YELLOW = 4'b0100;
    localparam logic [3:0] LAMP_RED    = 4'b1000;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    typedef enum logic [1:0] {
        A_TENS  = 2'd0,
        A_UNITS = 2'd1,
        B_TENS  = 2'd2,
        B_UNITS = 2'd3
    } digit_idx_t;

    // A lamp code is valid only with exactly one bit set.
    function automatic logic lamp_one_hot(input logic [3:0] code);
        return (code != 4'd0) && ((code & (code - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/traffic_disp_scan_if.sv
// Controller-to-display bundle: countdown/lamp inputs and the display/LED drive outputs.
interface traffic_disp_scan_if;
    logic       EN;
    logic [7:0] ACOUNT;
    logic [7:0] BCOUNT;
    logic [3:0] LAMPA;
    logic [3:0] LAMPB;
    logic [6:0] SEG;
    logic [3:0] DIG;
    logic [3:0] LEDA;
    logic [3:0] LEDB;

    modport master (
        output EN, ACOUNT, BCOUNT, LAMPA, LAMPB,
        input  SEG, DIG, LEDA, LEDB
    );

    modport slave (
        input  EN, ACOUNT, BCOUNT, LAMPA, LAMPB,
        output SEG, DIG, LEDA, LEDB
    );
endinterface

// File: rtl/traffic_disp_scan_bcd7seg.sv
// Nibble to 7-segment {g,f,e,d,c,b,a} decoder; non-decimal nibbles show a dash.
module bcd7seg
    import traffic_disp_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_DASH;
        case (nibble)
            4'd0: seg = 7'h3F;
            4'd1: seg = 7'h06;
            4'd2: seg = 7'h5B;
            4'd3: seg = 7'h4F;
            4'd4: seg = 7'h66;
            4'd5: seg = 7'h6D;
            4'd6: seg = 7'h7D;
            4'd7: seg = 7'h07;
            4'd8: seg = 7'h7F;
            4'd9: seg = 7'h6F;
            default: seg = SEG_DASH;
        endcase
        if (blank) begin
            seg = SEG_BLANK;
        end
    end
endmodule

// File: rtl/traffic_disp_scan.sv
// Multiplexed 4-digit countdown display and lamp LED driver with per-frame snapshot,
// leading-zero blanking, invalid-code dashes and flashing red on lamp faults.
module traffic_disp_scan
    import traffic_disp_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic              CLK,
    input  logic              RST_N,
    traffic_disp_scan_if.slave disp
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0]   presc_reg;
    digit_idx_t      idx_reg;
    logic [FW-1:0]   frame_reg;
    logic            blink_reg;
    logic [1:0][7:0] count_reg;
    logic [1:0][3:0] lamp_reg;
    logic [6:0]      seg_reg;
    logic [3:0]      dig_reg;
    logic [1:0][3:0] led_reg;

    logic            tick;
    logic            wrap;
    digit_idx_t      idx_next;
    logic [FW-1:0]   frame_next;
    logic            blink_next;
    logic [1:0][7:0] count_next;
    logic [1:0][3:0] lamp_next;
    logic [1:0]      lamp_ok;
    logic [1:0][3:0] led_next;
    logic            dir_sel;
    logic            is_tens;
    logic [3:0]      nibble_sel;
    logic            blank_sel;
    logic [6:0]      seg_dec;
    logic [3:0]      dig_next;

    // Display content is recomputed every cycle from the (possibly just captured)
    // snapshot, so re-enabling mid-slot shows the right digit immediately.
    always_comb begin
        tick       = (presc_reg == PRESC_LAST);
        wrap       = tick && (idx_reg == B_UNITS);
        idx_next   = tick ? digit_idx_t'(idx_reg + 2'd1) : idx_reg;
        count_next = wrap ? {disp.BCOUNT, disp.ACOUNT} : count_reg;
        lamp_next  = wrap ? {disp.LAMPB, disp.LAMPA} : lamp_reg;

        frame_next = frame_reg;
        blink_next = blink_reg;
        if (wrap) begin
            if (frame_reg == FRAME_LAST) begin
                frame_next = '0;
                blink_next = ~blink_reg;
            end else begin
                frame_next = frame_reg + FW'(1);
            end
        end

        dir_sel    = (idx_next == B_TENS) || (idx_next == B_UNITS);
        is_tens    = (idx_next == A_TENS) || (idx_next == B_TENS);
        nibble_sel = is_tens ? count_next[dir_sel][7:4] : count_next[dir_sel][3:0];
        blank_sel  = is_tens && (count_next[dir_sel][7:4] == 4'd0)
                     && (count_next[dir_sel][3:0] < 4'd10);
        if (!lamp_ok[dir_sel]) begin
            nibble_sel = 4'hF;
            blank_sel  = 1'b0;
        end

        dig_next           = 4'b1111;
        dig_next[idx_next] = 1'b0;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_dir
        assign lamp_ok[gi]  = lamp_one_hot(lamp_next[gi]);
        assign led_next[gi] = lamp_ok[gi] ? lamp_next[gi] : {blink_next, 3'b000};
    end

    bcd7seg u_dec (
        .nibble (nibble_sel),
        .blank  (blank_sel),
        .seg    (seg_dec)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            presc_reg <= '0;
            idx_reg   <= A_TENS;
            frame_reg <= '0;
            blink_reg <= 1'b1;
            count_reg <= '0;
            lamp_reg  <= '0;
            seg_reg   <= SEG_BLANK;
            dig_reg   <= 4'b1111;
            led_reg   <= '0;
        end else begin
            presc_reg <= tick ? '0 : presc_reg + PW'(1);
            idx_reg   <= idx_next;
            frame_reg <= frame_next;
            blink_reg <= blink_next;
            count_reg <= count_next;
            lamp_reg  <= lamp_next;
            seg_reg   <= disp.EN ? seg_dec : SEG_BLANK;
            dig_reg   <= disp.EN ? dig_next : 4'b1111;
            led_reg   <= led_next;
        end
    end

    assign disp.SEG  = seg_reg;
    assign disp.DIG  = dig_reg;
    assign disp.LEDA = led_reg[0];
    assign disp.LEDB = led_reg[1];
endmodule

// File: tb/tb_traffic_disp_scan.sv
// Self-checking bench: cycle-level reference model driven by edge counting plus directed scenarios.
module tb_traffic_disp_scan;
    import traffic_disp_pkg::*;

    localparam int SD    = 4;
    localparam int BF    = 2;
    localparam int FRAME = 4 * SD;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    traffic_disp_scan_if intf ();

    traffic_disp_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .disp  (intf)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [18:0] obs;
    assign obs = {intf.SEG, intf.DIG, intf.LEDA, intf.LEDB};

    logic [6:0] digit_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    logic [3:0] dig_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // Reference model: k_edges counts non-reset edges; slot, frame and blink phase
    // follow directly from that count.
    int          k_edges;
    logic [7:0]  m_ac, m_bc;
    logic [3:0]  m_la, m_lb;
    logic [18:0] exp_out;

    function automatic logic [6:0] ref_digit(input logic [7:0] cnt, input logic [3:0] lamp, input bit tens);
        int t = int'(cnt[7:4]);
        int u = int'(cnt[3:0]);
        if ($countones(lamp) != 1) return 7'h40;
        if (!tens) return (u < 10) ? digit_tab[u] : 7'h40;
        if (t > 9) return 7'h40;
        if (t == 0 && u < 10) return 7'h00;
        return digit_tab[t];
    endfunction

    always @(posedge clk) begin
        int nk, idx;
        bit blink;
        logic [7:0] ac, bc;
        logic [3:0] la, lb, eleda, eledb, dg;
        logic [6:0] sg;
        if (!rst_n) begin
            k_edges <= 0;
            m_ac <= 8'h00; m_bc <= 8'h00; m_la <= 4'h0; m_lb <= 4'h0;
            exp_out <= {7'h00, 4'hF, 4'h0, 4'h0};
        end else begin
            nk = k_edges + 1;
            ac = m_ac; bc = m_bc; la = m_la; lb = m_lb;
            if (nk % FRAME == 0) begin
                ac = intf.ACOUNT; bc = intf.BCOUNT; la = intf.LAMPA; lb = intf.LAMPB;
            end
            idx   = (nk / SD) % 4;
            blink = (((nk / FRAME) / BF) % 2) == 0;
            case (idx)
                0: sg = ref_digit(ac, la, 1'b1);
                1: sg = ref_digit(ac, la, 1'b0);
                2: sg = ref_digit(bc, lb, 1'b1);
                default: sg = ref_digit(bc, lb, 1'b0);
            endcase
            dg = 4'b1111;
            dg[idx] = 1'b0;
            eleda = ($countones(la) == 1) ? la : {blink, 3'b000};
            eledb = ($countones(lb) == 1) ? lb : {blink, 3'b000};
            if (intf.EN) exp_out <= {sg, dg, eleda, eledb};
            else         exp_out <= {7'h00, 4'hF, eleda, eledb};
            k_edges <= nk;
            m_ac <= ac; m_bc <= bc; m_la <= la; m_lb <= lb;
        end
    end

    // Advances to the negedge just after the next frame-wrap edge (at least one edge).
    task automatic wait_frame_start();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((k_edges % FRAME) != 0 && n < 4 * FRAME);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (obs !== {7'h00, 4'hF, 4'h0, 4'h0}) begin
                miscompares++;
                $display("FAIL reset_hold: got %h want %h", obs, {7'h00, 4'hF, 8'h00});
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_out) begin
                miscompares++;
                $display("FAIL reset_scan: cyc %0d got %h want %h", i, obs, exp_out);
            end
            vectors++;
            if (intf.DIG !== dig_seq[((i + 1) / SD) % 4]) begin
                miscompares++;
                $display("FAIL reset_dig_step: cyc %0d got %b want %b", i, intf.DIG, dig_seq[((i + 1) / SD) % 4]);
            end
        end
    endtask

    task automatic test_decode();
        logic [6:0] want [4] = '{7'h66, 7'h3F, 7'h00, 7'h6D};
        intf.EN = 1'b1; intf.ACOUNT = 8'h40; intf.BCOUNT = 8'h05;
        intf.LAMPA = LAMP_GREEN; intf.LAMPB = LAMP_RED;
        wait_frame_start();
        for (int i = 0; i < FRAME; i++) begin
            vectors++;
            if (obs !== exp_out) begin
                miscompares++;
                $display("FAIL decode_model: cyc %0d got %h want %h", i, obs, exp_out);
            end
            vectors++;
            if ({intf.SEG, intf.LEDA, intf.LEDB} !== {want[i / SD], 4'b0010, 4'b1000}) begin
                miscompares++;
                $display("FAIL decode_direct: cyc %0d got seg=%h leda=%b ledb=%b want seg=%h leda=0010 ledb=1000",
                         i, intf.SEG, intf.LEDA, intf.LEDB, want[i / SD]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_invalid_bcd();
        intf.ACOUNT = 8'h3A;
        wait_frame_start();
        for (int i = 0; i < 2 * SD; i++) begin
            vectors++;
            if (obs !== exp_out) begin
                miscompares++;
                $display("FAIL invalid_model: cyc %0d got %h want %h", i, obs, exp_out);
            end
            vectors++;
            if (intf.SEG !== ((i < SD) ? 7'h4F : 7'h40)) begin
                miscompares++;
                $display("FAIL invalid_direct: cyc %0d got %h want %h", i, intf.SEG, (i < SD) ? 7'h4F : 7'h40);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_snapshot();
        logic [6:0] want;
        intf.ACOUNT = 8'h12;
        wait_frame_start();
        for (int i = 0; i < FRAME + 2 * SD; i++) begin
            vectors++;
            if (obs !== exp_out) begin
                miscompares++;
                $display("FAIL snapshot_model: cyc %0d got %h want %h", i, obs, exp_out);
            end
            if ((i % FRAME) < 2 * SD) begin
                want = (i < SD || i >= FRAME) ? 7'h06 : 7'h5B;
                vectors++;
                if (intf.SEG !== want) begin
                    miscompares++;
                    $display("FAIL snapshot_direct: cyc %0d got %h want %h", i, intf.SEG, want);
                end
            end
            if (i == SD + 1) intf.ACOUNT = 8'h11;
            @(negedge clk);
        end
    endtask

    task automatic test_fault_blink();
        logic [3:0] leda_hist [4];
        intf.ACOUNT = 8'h25; intf.BCOUNT = 8'h37;
        intf.LAMPA = 4'b0110; intf.LAMPB = LAMP_GREEN;
        wait_frame_start();
        for (int i = 0; i < 4 * FRAME; i++) begin
            vectors++;
            if (obs !== exp_out) begin
                miscompares++;
                $display("FAIL fault_model: cyc %0d got %h want %h", i, obs, exp_out);
            end
            if ((i % FRAME) < 2 * SD) begin
                vectors++;
                if (intf.SEG !== 7'h40) begin
                    miscompares++;
                    $display("FAIL fault_dash: cyc %0d got %h want 40", i, intf.SEG);
                end
            end
            vectors++;
            if (intf.LEDB !== LAMP_GREEN) begin
                miscompares++;
                $display("FAIL fault_ledb: cyc %0d got %b want 0010", i, intf.LEDB);
            end
            if (i % FRAME == 0) leda_hist[i / FRAME] = intf.LEDA;
            @(negedge clk);
        end
        for (int f = 0; f < 2; f++) begin
            vectors++;
            if (!((leda_hist[f] ^ leda_hist[f + 2]) === 4'b1000 && leda_hist[f][2:0] === 3'b000)) begin
                miscompares++;
                $display("FAIL fault_blink: frame %0d leda=%b frame %0d leda=%b want opposite 1000/0000",
                         f, leda_hist[f], f + 2, leda_hist[f + 2]);
            end
        end
    endtask

    task automatic test_en_low();
        intf.ACOUNT = 8'h59; intf.BCOUNT = 8'h08;
        intf.LAMPA = LAMP_RED; intf.LAMPB = LAMP_LEFT;
        wait_frame_start();
        for (int i = 0; i < FRAME + 4; i++) begin
            vectors++;
            if (obs !== exp_out) begin
                miscompares++;
                $display("FAIL en_model: cyc %0d got %h want %h", i, obs, exp_out);
            end
            if (i >= 7 && i <= 11) begin
                vectors++;
                if ({intf.DIG, intf.SEG, intf.LEDA} !== {4'b1111, 7'h00, LAMP_RED}) begin
                    miscompares++;
                    $display("FAIL en_blank: cyc %0d got dig=%b seg=%h leda=%b want 1111/00/1000",
                             i, intf.DIG, intf.SEG, intf.LEDA);
                end
            end
            if (i == 12) begin
                vectors++;
                if ({intf.DIG, intf.SEG} !== {4'b0111, 7'h7F}) begin
                    miscompares++;
                    $display("FAIL en_resume: got dig=%b seg=%h want 0111/7f", intf.DIG, intf.SEG);
                end
            end
            if (i == 6)  intf.EN = 1'b0;
            if (i == 11) intf.EN = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_out) begin
                miscompares++;
                $display("FAIL random: cyc %0d got %h want %h", i, obs, exp_out);
            end
            rst_n = ($urandom_range(0, 299) != 0);
            intf.EN = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 5) == 0)
                intf.ACOUNT = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                              : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            if ($urandom_range(0, 5) == 0)
                intf.BCOUNT = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                              : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            if ($urandom_range(0, 15) == 0)
                intf.LAMPA = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0)
                intf.LAMPB = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
        end
        rst_n = 1'b1;
    endtask

    initial begin
        intf.EN = 1'b1;
        intf.ACOUNT = 8'h00; intf.BCOUNT = 8'h00;
        intf.LAMPA = 4'h0; intf.LAMPB = 4'h0;
        test_reset();
        test_decode();
        test_invalid_bcd();
        test_snapshot();
        test_fault_blink();
        test_en_low();
        test_random();
        test_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
